// File: rtl/cms_trace_engine.sv
// cms_trace_engine: captures retired {pc, instr} pairs into a trace FIFO
// gated by start/stop triggers and an address range filter, and streams them
// out over AXI-Stream. The tvalid/tdata/tlast outputs are driven from
// registers that are loaded with the next FIFO head on every clock.
module cms_trace_engine #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] WFI_INSTR  = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       instr,
    input  logic              pc_valid,
    input  logic [7:0]        ctrl_addr,
    input  logic [63:0]       ctrl_wdata,
    input  logic              ctrl_we,
    input  logic [31:0]       tlast_interval,
    output logic              M_AXIS_tvalid,
    input  logic              M_AXIS_tready,
    output logic [XLEN+31:0]  M_AXIS_tdata,
    output logic              M_AXIS_tlast,
    output logic [1:0]        state,
    output logic [31:0]       drop_count,
    output logic              overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = XLEN + 33;   // {pc, instr, tlast}
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [7:0] ADDR_START_EN   = 8'd0;
    localparam logic [7:0] ADDR_END_EN     = 8'd1;
    localparam logic [7:0] ADDR_START_ADDR = 8'd2;
    localparam logic [7:0] ADDR_END_ADDR   = 8'd3;
    localparam logic [7:0] ADDR_LO_EN      = 8'd4;
    localparam logic [7:0] ADDR_HI_EN      = 8'd5;
    localparam logic [7:0] ADDR_LO_BOUND   = 8'd6;
    localparam logic [7:0] ADDR_HI_BOUND   = 8'd7;
    localparam logic [7:0] ADDR_ARM        = 8'd8;
    localparam logic [7:0] ADDR_HALT       = 8'd9;
    localparam logic [7:0] ADDR_CLEAR      = 8'd10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_TRACING    = 2'd2,
        ST_STOPPED    = 2'd3
    } trace_state_e;

    trace_state_e    state_r, state_next_s;

    logic            start_en_r, end_en_r, lo_en_r, hi_en_r;
    logic [XLEN-1:0] start_addr_r, end_addr_r, lo_bound_r, hi_bound_r;

    logic [EW-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CW-1:0]   count_r, cnt_after_pop_s, count_next_s;
    logic [31:0]     pkt_cnt_r;
    logic [31:0]     drop_cnt_r;
    logic            overflow_r;
    logic            tvalid_r, tlast_r;
    logic [XLEN+31:0] tdata_r;

    logic            arm_s, arm_ok_s, halt_s, clear_s;
    logic            in_range_s, start_fire_s, stop_fire_s;
    logic            push_s, pop_s, full_s, accept_s, drop_s, tlast_item_s;
    logic [EW-1:0]   push_entry_s, head_next_s;

    // Control strobes decoded straight from the write port.
    assign arm_s    = ctrl_we && (ctrl_addr == ADDR_ARM)  && ctrl_wdata[0];
    assign halt_s   = ctrl_we && (ctrl_addr == ADDR_HALT) && ctrl_wdata[0];
    assign clear_s  = ctrl_we && (ctrl_addr == ADDR_CLEAR);
    assign arm_ok_s = arm_s && ((state_r == ST_IDLE) || (state_r == ST_STOPPED));

    // Triggers and filter always use the register values from before any
    // write landing on the same edge.
    assign in_range_s   = (!lo_en_r || (pc >= lo_bound_r)) && (!hi_en_r || (pc <= hi_bound_r));
    assign start_fire_s = (state_r == ST_WAIT_START) && pc_valid && (pc == start_addr_r);
    assign stop_fire_s  = (state_r == ST_TRACING) && pc_valid &&
                          ((end_en_r && (pc == end_addr_r)) || (instr == WFI_INSTR));

    // A HALT in the same cycle wins over capture as well as over the triggers.
    assign push_s       = pc_valid && in_range_s && !halt_s &&
                          ((state_r == ST_TRACING) || start_fire_s);
    assign tlast_item_s = stop_fire_s ||
                          ((tlast_interval != 32'd0) && (pkt_cnt_r == (tlast_interval - 32'd1)));
    assign full_s       = (count_r == FULL_CNT);
    assign pop_s        = tvalid_r && M_AXIS_tready;
    assign accept_s     = push_s && (!full_s || pop_s);
    assign drop_s       = push_s && full_s && !pop_s;
    assign push_entry_s = {pc, instr, tlast_item_s};

    // Next trace state: HALT, then ARM, then the capture triggers.
    always_comb begin
        state_next_s = state_r;
        if (halt_s) begin
            state_next_s = ST_STOPPED;
        end else if (arm_ok_s) begin
            state_next_s = start_en_r ? ST_WAIT_START : ST_TRACING;
        end else begin
            case (state_r)
                ST_WAIT_START: begin
                    if (start_fire_s) begin
                        state_next_s = ST_TRACING;
                    end else begin
                        state_next_s = ST_WAIT_START;
                    end
                end
                ST_TRACING: begin
                    if (stop_fire_s) begin
                        state_next_s = ST_STOPPED;
                    end else begin
                        state_next_s = ST_TRACING;
                    end
                end
                ST_IDLE:    state_next_s = ST_IDLE;
                ST_STOPPED: state_next_s = ST_STOPPED;
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // Trace state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Configuration registers written through the ctrl port.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_en_r   <= 1'b0;
            end_en_r     <= 1'b0;
            lo_en_r      <= 1'b0;
            hi_en_r      <= 1'b0;
            start_addr_r <= {XLEN{1'b0}};
            lo_bound_r   <= {XLEN{1'b0}};
            end_addr_r   <= {XLEN{1'b1}};
            hi_bound_r   <= {XLEN{1'b1}};
        end else if (ctrl_we) begin
            case (ctrl_addr)
                ADDR_START_EN:   start_en_r   <= ctrl_wdata[0];
                ADDR_END_EN:     end_en_r     <= ctrl_wdata[0];
                ADDR_START_ADDR: start_addr_r <= ctrl_wdata[XLEN-1:0];
                ADDR_END_ADDR:   end_addr_r   <= ctrl_wdata[XLEN-1:0];
                ADDR_LO_EN:      lo_en_r      <= ctrl_wdata[0];
                ADDR_HI_EN:      hi_en_r      <= ctrl_wdata[0];
                ADDR_LO_BOUND:   lo_bound_r   <= ctrl_wdata[XLEN-1:0];
                ADDR_HI_BOUND:   hi_bound_r   <= ctrl_wdata[XLEN-1:0];
                default:         start_en_r   <= start_en_r;
            endcase
        end
    end

    // Look ahead to the FIFO head after this edge so the outputs can be registered.
    always_comb begin
        cnt_after_pop_s = count_r - CW'(pop_s);
        count_next_s    = cnt_after_pop_s + CW'(accept_s);
        rd_next_s       = rd_ptr_r + AW'(pop_s);
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {EW{1'b0}};
        end else if (accept_s && (cnt_after_pop_s == {CW{1'b0}})) begin
            head_next_s = push_entry_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // FIFO pointers, occupancy and the registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            tvalid_r <= 1'b0;
            tdata_r  <= {(XLEN+32){1'b0}};
            tlast_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(accept_s);
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            tvalid_r <= (count_next_s != {CW{1'b0}});
            tdata_r  <= head_next_s[EW-1:1];
            tlast_r  <= head_next_s[0];
        end
    end

    // Packet counter: restarts on ARM and after every item that closes a packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_r <= 32'd0;
        end else if (arm_ok_s) begin
            pkt_cnt_r <= 32'd0;
        end else if (accept_s) begin
            pkt_cnt_r <= tlast_item_s ? 32'd0 : (pkt_cnt_r + 32'd1);
        end
    end

    // Drop statistics: saturating counter and sticky flag; a drop in the CLEAR cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 32'd0;
            overflow_r <= 1'b0;
        end else if (clear_s) begin
            drop_cnt_r <= drop_s ? 32'd1 : 32'd0;
            overflow_r <= drop_s;
        end else if (drop_s) begin
            drop_cnt_r <= (drop_cnt_r == 32'hFFFF_FFFF) ? drop_cnt_r : (drop_cnt_r + 32'd1);
            overflow_r <= 1'b1;
        end
    end

    assign M_AXIS_tvalid = tvalid_r;
    assign M_AXIS_tdata  = tdata_r;
    assign M_AXIS_tlast  = tlast_r;
    assign state         = state_r;
    assign drop_count    = drop_cnt_r;
    assign overflow      = overflow_r;

endmodule

// File: doc/cms_trace_engine.md
CMS_TRACE_ENGINE -- requirements
Module: cms_trace_engine

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning trace buffer entries; power of 2, at least 2.
REQ-003 SHALL have parameter WFI_INSTR, default 32'h0001, meaning the encoding that terminates tracing.
REQ-004 SHALL have port clk, input, width 1; single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, width 1; reset is synchronous and active-high.
REQ-006 SHALL have ports pc, input, XLEN, and instr, input, 32; the retired instruction and its PC.
REQ-007 SHALL have port pc_valid, input, 1; pc/instr are sampled only when it is 1.
REQ-008 SHALL have port ctrl_addr, input, 8; register select.
REQ-009 SHALL have port ctrl_wdata, input, 64; write data.
REQ-010 SHALL have port ctrl_we, input, 1; level-triggered, one write per cycle high.
REQ-011 SHALL have port tlast_interval, input, 32; number of items per packet, 0 = only forced tlast.
REQ-012 SHALL have ports M_AXIS_tvalid out 1, M_AXIS_tready in 1, M_AXIS_tdata out XLEN+32 ({pc,instr}), M_AXIS_tlast out 1.
REQ-013 SHALL have port state, output, 2: 0 IDLE, 1 WAIT_START, 2 TRACING, 3 STOPPED.
REQ-014 SHALL have ports drop_count, output, 32 (saturating), and overflow, output, 1 (sticky).

Function
REQ-015 SHALL decode these ctrl registers: 0 start_en, 1 end_en, 2 start_addr, 3 end_addr, 4 lo_en, 5 hi_en, 6 lo_bound, 7 hi_bound. Enables use bit 0; addresses use bits XLEN-1:0.
REQ-016 SHALL treat a write to address 8 (ARM) with wdata[0]=1 as follows: from IDLE or STOPPED, go to WAIT_START if start_en=1, else to TRACING; clear the packet counter. Ignore the write in other states.
REQ-017 SHALL treat a write to address 9 (HALT) with wdata[0]=1 as: any state goes to STOPPED; no item is pushed.
REQ-018 SHALL treat a write to address 10 (CLEAR) as: clear drop_count and overflow. Other addresses are ignored.
REQ-019 SHALL apply the range filter: in_range = (!lo_en or pc >= lo_bound) and (!hi_en or pc <= hi_bound), unsigned compare.
REQ-020 WAIT_START SHALL go to TRACING on pc_valid with pc == start_addr; that item is eligible for capture in the same cycle.
REQ-021 TRACING SHALL go to STOPPED on pc_valid with either end_en=1 and pc == end_addr, or instr == WFI_INSTR. That item is eligible and carries forced tlast=1.
REQ-022 SHALL push an item when pc_valid, in_range, and (state == TRACING or the REQ-020 transition is firing). Push and FIFO write complete on the same edge.
REQ-023 SHALL make a pushed item visible on M_AXIS_tvalid on the following cycle (1-cycle latency). Output order SHALL be FIFO.
REQ-024 SHALL pop on tvalid and tready. tdata/tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-025 SHALL count pushes with the packet counter. Set tlast when counter == tlast_interval-1 (and tlast_interval != 0) or when tlast is forced; the counter resets to 0 after any tlast item.
REQ-026 SHALL allow a push to a full FIFO when a pop happens in the same cycle. Otherwise, a push to a full FIFO SHALL drop the item, increment drop_count (saturating at 2^32-1), set overflow, and leave the packet counter unchanged.
REQ-027 SHALL apply state transitions even when the triggering item is dropped or out of range.
REQ-028 SHALL, when a ctrl write and a trigger occur in the same cycle, evaluate the trigger with pre-write register values. HALT/ARM take priority over trigger transitions.
REQ-029 SHALL NOT flush the FIFO on entering STOPPED; buffered items continue to drain.

Reset
REQ-030 SHALL, while rst=1, go to state IDLE; set the FIFO empty, M_AXIS_tvalid=0, M_AXIS_tlast=0, drop_count=0, overflow=0, packet counter 0.
REQ-031 SHALL, while rst=1, reset start_en, end_en, lo_en, hi_en to 0; start_addr and lo_bound to 0; end_addr and hi_bound to all-ones.
REQ-032 SHALL, on reset during TRACING, discard buffered items; output SHALL be tvalid=0 the cycle after rst is sampled high.

Verification
REQ-033 Scenario: ARM with start_en=0, 5 valid PCs, tlast_interval=2, tready=1 -> 5 beats, tlast on beats 2 and 4.
REQ-034 Scenario: start_en=1, start_addr=0x100, PCs 0xFC,0x100,0x104 -> state 1 to 2 at 0x100; beats 0x100, 0x104.
REQ-035 Scenario: TRACING, instr=0x0001 at pc 0x200 -> beat 0x200 with tlast=1; state=3; later PCs are not captured.
REQ-036 Scenario: lo_en=hi_en=1, bounds 0x10..0x20, PCs 0x0C,0x10,0x20,0x24 -> only 0x10 and 0x20 output.
REQ-037 Scenario: tready=0, FIFO_DEPTH+3 pushes -> drop_count=3, overflow=1; full + push + pop in the same cycle drops nothing; CLEAR -> 0.
REQ-038 Scenario: rst asserted mid-TRACING with 4 items buffered -> next cycle tvalid=0, state=0, end_addr reads back all-ones behaviour.
